score_bcd_counter: RTL
======================

# score_bcd_counter

Game score counter for the Flappy Bird datapath. Counts pipes cleared by the bird in three BCD digits and drives them, zero-extended to 10 bits, straight into the per-digit seven-segment decoders. Sits between the pipe/collision logic (upstream) and the HEX display decoders (downstream). Optionally keeps a session high score.

## Interface
Parameters:
- MAX_SCORE, 999: saturation value, decimal, 1..999.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- game_start  in  1  level; clears score and enters PLAY (synchronous).
- pipe_passed  in  1  level from pipe logic; each rising edge is one point.
- game_over  in  1  level; freezes score, enters OVER.
- score_ones  out  10  current ones digit, 0..9, zero-extended.
- score_tens  out  10  current tens digit.
- score_hund  out  10  current hundreds digit.
- hi_ones / hi_tens / hi_hund  out  10 each  high-score digits (present only with SCORE_HIGH_EN).
- new_high  out  1  one-cycle pulse when high score is replaced (only with SCORE_HIGH_EN).
- saturated  out  1  score == MAX_SCORE.
- state_o  out  2  FSM state: 00 IDLE, 01 PLAY, 10 OVER.

## Operation
- FSM: IDLE -> PLAY on game_start; PLAY -> OVER on game_over; OVER -> PLAY on game_start; PLAY -> PLAY on game_start (restart, score cleared). No other transitions. game_start has priority over game_over in the same cycle.
- Edge detect: pipe_q registers pipe_passed every cycle in all states. inc = pipe_passed & ~pipe_q & (state == PLAY) & ~game_over & ~game_start.
- Increment: ones+1; ones 9 -> 0 carries to tens; tens 9 -> 0 carries to hundreds. Digits never leave 0..9; upper 6 bits of every digit output are always 0.
- Saturation: when score equals MAX_SCORE, inc is ignored, score holds, saturated = 1. Cleared by game_start or reset.
- game_over in same cycle as an edge: edge dropped, score frozen at prior value.
- game_start clears all score digits to 0 and saturated to 0; pipe_q still loads, so a level held high across restart does not count.
- IDLE and OVER: score holds; edges ignored.
- Reset (any time, including mid-game): state IDLE, all digits 0, pipe_q 0, saturated 0, new_high 0, high score 0.

## Timing
- Score update latency: 1 cycle from the clock edge where the pipe_passed rising edge is first sampled high; outputs are registered.
- Maximum count rate: one point per 2 cycles (pipe_passed must return low for at least one cycle).
- High-score update: on the PLAY->OVER transition edge, compare final score (hund, tens, ones lexicographic) against high score; if strictly greater, high score loads the score on that edge and new_high is 1 for exactly the next cycle. Equal score does not update.
- state_o is registered; reflects the transition 1 cycle after the causing input.

## Configuration
- SCORE_HIGH_EN defined: high-score registers, comparator, hi_* and new_high ports present; high score survives game_start, cleared only by reset_n.
- SCORE_HIGH_EN undefined: that logic and those ports are removed; all other behaviour identical.

## Test plan
- Reset mid-game: score 0,4,7, assert reset_n low asynchronously -> all outputs 0, state_o 00 immediately, no clock needed.
- Count and carry: game_start, then 10 pulses of pipe_passed (1 high, 1 low) -> score 0,1,0; after 100 total -> 1,0,0, each update 1 cycle after edge.
- Held level: pipe_passed high for 20 cycles in PLAY -> score increments by exactly 1; high across game_start -> score stays 0.
- Saturation: MAX_SCORE=12, 15 pulses -> score 0,1,2, saturated=1; game_start -> 0,0,0, saturated=0.
- Simultaneous events: pipe edge and game_over same cycle at score 5 -> score 5, state OVER; edges in OVER ignored.
- High score (SCORE_HIGH_EN): game 1 ends at 7 -> hi 0,0,7, new_high 1 cycle; game 2 ends at 7 -> no pulse; game 3 ends at 12 -> hi 0,1,2, pulse.

Source files
------------

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: three-digit BCD game score with pipe-edge counting,
// saturation at MAX_SCORE and an optional session high score.
// Optional feature macro: SCORE_HIGH_EN (high-score registers and ports).
module score_bcd_counter #(
  parameter int unsigned MAX_SCORE = 999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       game_start,
  input  logic       pipe_passed,
  input  logic       game_over,
  output logic [9:0] score_ones,
  output logic [9:0] score_tens,
  output logic [9:0] score_hund,
`ifdef SCORE_HIGH_EN
  output logic [9:0] hi_ones,
  output logic [9:0] hi_tens,
  output logic [9:0] hi_hund,
  output logic       new_high,
`endif
  output logic       saturated,
  output logic [1:0] state_o
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned OUT_W   = 10;

  localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MAX_SCORE % 10);
  localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'((MAX_SCORE / 10) % 10);
  localparam logic [DIGIT_W-1:0] MAX_HUND = DIGIT_W'((MAX_SCORE / 100) % 10);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t             state;
  logic               pipe_q;
  logic               sat_q;
  logic [DIGIT_W-1:0] ones, tens, hund;
  logic [DIGIT_W-1:0] ones_nxt, tens_nxt, hund_nxt;
  logic               inc;
  logic               play_end;

  // Rising edge of pipe_passed while playing and no control event pending
  assign inc = pipe_passed & ~pipe_q & (state == PLAY) & ~game_over & ~game_start;

  // PLAY -> OVER transition on this edge (game_start wins over game_over)
  assign play_end = (state == PLAY) & game_over & ~game_start;

  // Game state: start/restart from any state, end only from PLAY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (game_start) begin
      state <= PLAY;
    end else if (play_end) begin
      state <= OVER;
    end
  end

  // Previous pipe_passed level, loaded in every state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= 1'b0;
    end else begin
      pipe_q <= pipe_passed;
    end
  end

  // BCD increment with ripple carry from ones to hundreds
  always_comb begin
    ones_nxt = ones;
    tens_nxt = tens;
    hund_nxt = hund;
    if (ones == DIGIT_W'(9)) begin
      ones_nxt = '0;
      if (tens == DIGIT_W'(9)) begin
        tens_nxt = '0;
        hund_nxt = (hund == DIGIT_W'(9)) ? '0 : hund + DIGIT_W'(1);
      end else begin
        tens_nxt = tens + DIGIT_W'(1);
      end
    end else begin
      ones_nxt = ones + DIGIT_W'(1);
    end
  end

  // Score digits and saturation flag; saturated score ignores further edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ones  <= '0;
      tens  <= '0;
      hund  <= '0;
      sat_q <= 1'b0;
    end else if (game_start) begin
      ones  <= '0;
      tens  <= '0;
      hund  <= '0;
      sat_q <= 1'b0;
    end else if (inc && !sat_q) begin
      ones  <= ones_nxt;
      tens  <= tens_nxt;
      hund  <= hund_nxt;
      sat_q <= (ones_nxt == MAX_ONES) && (tens_nxt == MAX_TENS) && (hund_nxt == MAX_HUND);
    end
  end

`ifdef SCORE_HIGH_EN
  logic [DIGIT_W-1:0] hi_ones_q, hi_tens_q, hi_hund_q;
  logic               new_high_q;
  logic               beats_high;

  // BCD digits compare lexicographically as a plain 12-bit number
  assign beats_high = {hund, tens, ones} > {hi_hund_q, hi_tens_q, hi_ones_q};

  // High score captured at game end when strictly exceeded; survives restarts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_ones_q  <= '0;
      hi_tens_q  <= '0;
      hi_hund_q  <= '0;
      new_high_q <= 1'b0;
    end else begin
      new_high_q <= 1'b0;
      if (play_end && beats_high) begin
        hi_ones_q  <= ones;
        hi_tens_q  <= tens;
        hi_hund_q  <= hund;
        new_high_q <= 1'b1;
      end
    end
  end

  assign hi_ones  = OUT_W'(hi_ones_q);
  assign hi_tens  = OUT_W'(hi_tens_q);
  assign hi_hund  = OUT_W'(hi_hund_q);
  assign new_high = new_high_q;
`endif

  assign score_ones = OUT_W'(ones);
  assign score_tens = OUT_W'(tens);
  assign score_hund = OUT_W'(hund);
  assign saturated  = sat_q;
  assign state_o    = state;

endmodule
